// File: rtl/program_loader.sv
// program_loader: boot-time loader between the host byte link and program memory.
// Assembles 16-bit instructions from a byte stream (header N, N x {lo, hi}, XOR checksum),
// writes them to program memory, and releases the core once the checksum matches.
// Optional build macro: LOADER_TIMEOUT_EN adds a stall timeout on the LO/HI/CSUM phases.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_HDR   | waiting for the word-count header byte N
// S_LO    | waiting for an instruction low byte
// S_HI    | waiting for an instruction high byte (write issued next cycle)
// S_CSUM  | waiting for the XOR checksum byte
// S_DONE  | load good, core released (core_run=1)
// S_ERROR | load failed (err=1), core held
module program_loader #(
  parameter int INSTR_WIDTH    = 16,
  parameter int BYTE_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                  core_run,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LO, S_HI, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH:0]    n_q, n_d;
  // One bit wider than the address so it doubles as the written-word count.
  logic [ADDR_WIDTH:0]    idx_q, idx_d;
  logic [BYTE_WIDTH-1:0]  lo_q, lo_d;
  logic [BYTE_WIDTH-1:0]  csum_q, csum_d;
  logic                   pm_we_q, pm_we_d;
  logic [ADDR_WIDTH-1:0]  pm_addr_q, pm_addr_d;
  logic [INSTR_WIDTH-1:0] pm_wdata_q, pm_wdata_d;
  logic [ADDR_WIDTH:0]    instr_count_q, instr_count_d;

  logic                   accept;
  logic [31:0]            hdr_ext;
  logic [ADDR_WIDTH:0]    idx_inc;

  assign rx_ready = (state_q == S_HDR) || (state_q == S_LO) ||
                    (state_q == S_HI)  || (state_q == S_CSUM);
  assign accept   = rx_ready && rx_valid;
  assign hdr_ext  = 32'(rx_data);
  assign idx_inc  = idx_q + (ADDR_WIDTH+1)'(1);

`ifdef LOADER_TIMEOUT_EN
  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LOAD = SW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          timed;

  assign timed = (state_q == S_LO) || (state_q == S_HI) || (state_q == S_CSUM);
`endif

  // Next-state and datapath updates; the stall timeout, when built in, overrides last.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    idx_d         = idx_q;
    lo_d          = lo_q;
    csum_d        = csum_q;
    pm_we_d       = 1'b0;
    pm_addr_d     = pm_addr_q;
    pm_wdata_d    = pm_wdata_q;
    instr_count_d = instr_count_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d       = S_HDR;
          instr_count_d = '0;
          idx_d         = '0;
          csum_d        = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          if ((hdr_ext == 32'd0) || (hdr_ext > MAX_WORDS)) begin
            state_d = S_ERROR;
          end else begin
            n_d     = (ADDR_WIDTH+1)'(rx_data);
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          lo_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (accept) begin
          pm_we_d    = 1'b1;
          pm_addr_d  = idx_q[ADDR_WIDTH-1:0];
          pm_wdata_d = INSTR_WIDTH'({rx_data, lo_q});
          csum_d     = csum_q ^ rx_data;
          idx_d      = idx_inc;
          state_d    = (idx_inc == n_q) ? S_CSUM : S_LO;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (rx_data == csum_q) begin
            state_d       = S_DONE;
            instr_count_d = n_q;
          end else begin
            state_d       = S_ERROR;
            instr_count_d = idx_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    stall_d = STALL_LOAD;
    if (timed && !accept) begin
      if (stall_q == '0) begin
        state_d       = S_ERROR;
        instr_count_d = idx_q;
      end else begin
        stall_d = stall_q - SW'(1);
      end
    end
`endif
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      idx_q         <= '0;
      lo_q          <= '0;
      csum_q        <= '0;
      pm_we_q       <= 1'b0;
      pm_addr_q     <= '0;
      pm_wdata_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      lo_q          <= lo_d;
      csum_q        <= csum_d;
      pm_we_q       <= pm_we_d;
      pm_addr_q     <= pm_addr_d;
      pm_wdata_q    <= pm_wdata_d;
      instr_count_q <= instr_count_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Stall down-counter; reloaded whenever a byte is taken or outside the timed states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= STALL_LOAD;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  assign pm_we       = pm_we_q;
  assign pm_addr     = pm_addr_q;
  assign pm_wdata    = pm_wdata_q;
  assign instr_count = instr_count_q;
  assign core_run    = (state_q == S_DONE);
  assign err         = (state_q == S_ERROR);
  assign busy        = rx_ready;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed byte streams; expected program-memory
// writes go into a queue that a separate monitor pops whenever pm_we is seen.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        pm_we;
  logic [4:0]  pm_addr;
  logic [15:0] pm_wdata;
  logic        core_run;
  logic        busy;
  logic        err;
  logic [5:0]  instr_count;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] byte_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  program_loader #(
    .INSTR_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .core_run(core_run), .busy(busy), .err(err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL pm_write unexpected: addr %0h data %0h", pm_addr, pm_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (pm_addr === e.addr && pm_wdata === e.data) pass_cnt++;
        else $display("FAIL pm_write: got addr %0h data %0h expected addr %0h data %0h",
                      pm_addr, pm_wdata, e.addr, e.data);
      end
    end
  end

  task automatic push_wr(input logic [4:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Present one byte and return at the negedge after it was accepted.
  task automatic send(input logic [7:0] b);
    int t;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total_cnt++;
      $display("FAIL send_timeout: rx_ready %0b required 1 for byte %0h", rx_ready, b);
    end
    @(negedge clk);
  endtask

  task automatic stream(input bit gap);
    while (byte_q.size() > 0) begin
      send(byte_q.pop_front());
      if (gap) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset core_run", 32'(core_run), 0);
    chk("reset err", 32'(err), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset rx_ready", 32'(rx_ready), 0);
    chk("reset pm_we", 32'(pm_we), 0);
    chk("reset instr_count", 32'(instr_count), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle rx_ready", 32'(rx_ready), 0);
    pulse_start();
    chk("start rx_ready", 32'(rx_ready), 1);
    chk("start busy", 32'(busy), 1);

    // Good load, back-to-back.
    push_wr(5'd0, 16'h1234);
    push_wr(5'd1, 16'hABCD);
    byte_q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    stream(1'b0);
    chk("good core_run", 32'(core_run), 1);
    chk("good err", 32'(err), 0);
    chk("good busy", 32'(busy), 0);
    chk("good instr_count", 32'(instr_count), 2);

    // Bad checksum.
    pulse_start();
    chk("restart core_run", 32'(core_run), 0);
    chk("restart instr_count", 32'(instr_count), 0);
    push_wr(5'd0, 16'h1234);
    push_wr(5'd1, 16'hABCD);
    byte_q = '{8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    stream(1'b0);
    chk("badcsum err", 32'(err), 1);
    chk("badcsum core_run", 32'(core_run), 0);
    chk("badcsum instr_count", 32'(instr_count), 2);
    pulse_start();
    chk("err cleared by start", 32'(err), 0);

    // Header N=0.
    send(8'h00);
    rx_valid = 1'b0;
    chk("hdr0 err", 32'(err), 1);
    chk("hdr0 instr_count", 32'(instr_count), 0);

    // Header N=33.
    pulse_start();
    send(8'h21);
    rx_valid = 1'b0;
    chk("hdr33 err", 32'(err), 1);
    chk("hdr33 busy", 32'(busy), 0);

    // Header N=32, all-zero payload.
    pulse_start();
    byte_q.push_back(8'h20);
    for (int i = 0; i < 64; i++) byte_q.push_back(8'h00);
    byte_q.push_back(8'h00);
    for (int i = 0; i < 32; i++) push_wr(5'(i), 16'h0000);
    stream(1'b0);
    chk("full core_run", 32'(core_run), 1);
    chk("full instr_count", 32'(instr_count), 32);
    chk("full err", 32'(err), 0);

    // Load with a bubble after every byte; checksum 01^02^03^04 = 04.
    pulse_start();
    push_wr(5'd0, 16'h0201);
    push_wr(5'd1, 16'h0403);
    byte_q = '{8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    stream(1'b1);
    chk("gap core_run", 32'(core_run), 1);
    chk("gap instr_count", 32'(instr_count), 2);

    // Byte held while not ready is not consumed; becomes the header after start.
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    repeat (3) @(negedge clk);
    chk("held byte core_run", 32'(core_run), 1);
    pulse_start();
    push_wr(5'd0, 16'h6655);
    byte_q = '{8'h01, 8'h55, 8'h66, 8'h33};
    stream(1'b0);
    chk("held core_run", 32'(core_run), 1);
    chk("held instr_count", 32'(instr_count), 1);

    // Reset while waiting for the high byte.
    pulse_start();
    send(8'h01);
    send(8'h77);
    rx_data = 8'h88;
    #2 rst = 1'b0;
    #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset rx_ready", 32'(rx_ready), 0);
    chk("midreset core_run", 32'(core_run), 0);
    chk("midreset instr_count", 32'(instr_count), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("postreset busy", 32'(busy), 0);
    chk("postreset pm_we", 32'(pm_we), 0);

`ifdef LOADER_TIMEOUT_EN
    // 15 idle cycles are tolerated.
    pulse_start();
    send(8'h01);
    send(8'h11);
    rx_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("stall15 err", 32'(err), 0);
    chk("stall15 busy", 32'(busy), 1);
    push_wr(5'd0, 16'h2211);
    send(8'h22);
    send(8'h33);
    rx_valid = 1'b0;
    chk("stall15 core_run", 32'(core_run), 1);

    // 16 idle cycles time out.
    pulse_start();
    send(8'h01);
    send(8'h11);
    rx_valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("stall16 err", 32'(err), 1);
    chk("stall16 instr_count", 32'(instr_count), 0);
`endif

    repeat (2) @(negedge clk);
    chk("expected writes drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
